// File: rtl/iic_slave_resp.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// iic_slave_resp
// I2C target that answers 8-bit device address / 16-bit register address /
// 8-bit data transactions. SCL and SDA are oversampled in the clk_8m domain.
// A small register file supports single and auto-increment burst writes and
// reads. Each accepted write byte is announced with a one-cycle strobe.
//
// Ports
//   clk_8m   in   system clock, at least 20x the SCL rate
//   rst      in   asynchronous active-high reset
//   scl      in   I2C clock (never stretched by this block)
//   sda      io   I2C data, open drain: driven 0 or released (Z)
//   busy     out  high from an address match until START, STOP or read NACK
//   wr_stb   out  one-cycle pulse per accepted write data byte
//   wr_addr  out  register address of the byte flagged by wr_stb
//   wr_data  out  data byte flagged by wr_stb
//   err      out  sticky: out-of-range access or START/STOP inside a byte
//
// DEPTH must be a power of two between 2 and 256.
// ---------------------------------------------------------------------------
module iic_slave_resp #(
   parameter logic [6:0] DEV_ADDR = 7'h50,
   parameter int         DEPTH    = 16,
   parameter logic [7:0] RST_VAL  = 8'h00
) (
   input  logic        clk_8m,
   input  logic        rst,
   input  logic        scl,
   inout  wire         sda,
   output logic        busy,
   output logic        wr_stb,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        err
);

   localparam int          IDX_W   = $clog2(DEPTH);
   localparam logic [15:0] DEPTH_W = 16'(DEPTH);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEV,
      ST_ACK_DEV,
      ST_REG_HI,
      ST_ACK_HI,
      ST_REG_LO,
      ST_ACK_LO,
      ST_WR_BYTE,
      ST_ACK_WR,
      ST_RD_BYTE,
      ST_RD_ACK
   } stateT;

   // Synchronizers and one-cycle history
   logic sclMeta_q, sclSync_q, sclPrev_q;
   logic sdaMeta_q, sdaSync_q, sdaPrev_q;

   // Protocol state
   stateT       state_q,   state_d;
   logic [3:0]  bitCnt_q,  bitCnt_d;
   logic        rxArmed_q, rxArmed_d;
   logic [6:0]  shift_q,   shift_d;
   logic [6:0]  tx_q,      tx_d;
   logic        sdaOe_q,   sdaOe_d;
   logic        ackOk_q,   ackOk_d;
   logic        rdMode_q,  rdMode_d;
   logic [15:0] ptr_q,     ptr_d;
   logic        busy_q,    busy_d;
   logic        err_q,     err_d;
   logic        wrStb_q,   wrStb_d;
   logic [15:0] wrAddr_q,  wrAddr_d;
   logic [7:0]  wrData_q,  wrData_d;

   // Register file
   logic [7:0]       mem_q [DEPTH];
   logic             memWe;
   logic [IDX_W-1:0] memIdx;
   logic [7:0]       memWdata;

   logic             sclRise, sclFall, sdaRise, sdaFall;
   logic             startDet, stopDet;
   logic [7:0]       rxByte;
   logic             ptrInRange;
   logic [IDX_W-1:0] ptrIdx;
   logic [7:0]       rdData;
   logic             startRead;

   // Open-drain pad: only ever pull low or let go. Because sdaOe_q is reset
   // asynchronously, a reset releases the line without waiting for a clock.
   assign sda = sdaOe_q ? 1'b0 : 1'bz;

   assign busy    = busy_q;
   assign wr_stb  = wrStb_q;
   assign wr_addr = wrAddr_q;
   assign wr_data = wrData_q;
   assign err     = err_q;

   // Bring SCL and SDA into the clk_8m domain through two flops each and
   // keep one extra cycle of history for edge detection. Everything resets
   // to 1 so an idle bus produces no edges when reset is released.
   always_ff @(posedge clk_8m or posedge rst) begin
      if (rst) begin
         sclMeta_q <= 1'b1;
         sclSync_q <= 1'b1;
         sclPrev_q <= 1'b1;
         sdaMeta_q <= 1'b1;
         sdaSync_q <= 1'b1;
         sdaPrev_q <= 1'b1;
      end else begin
         sclMeta_q <= scl;
         sclSync_q <= sclMeta_q;
         sclPrev_q <= sclSync_q;
         sdaMeta_q <= sda;
         sdaSync_q <= sdaMeta_q;
         sdaPrev_q <= sdaSync_q;
      end
   end

   assign sclRise  =  sclSync_q & ~sclPrev_q;
   assign sclFall  = ~sclSync_q &  sclPrev_q;
   assign sdaRise  =  sdaSync_q & ~sdaPrev_q;
   assign sdaFall  = ~sdaSync_q &  sdaPrev_q;
   assign startDet =  sdaFall & sclSync_q;
   assign stopDet  =  sdaRise & sclSync_q;

   // The byte as it stands once the bit now on the bus is shifted in.
   assign rxByte     = {shift_q, sdaSync_q};
   assign ptrInRange = (ptr_q < DEPTH_W);
   assign ptrIdx     = ptr_q[IDX_W-1:0];
   assign rdData     = ptrInRange ? mem_q[ptrIdx] : 8'hFF;

   // Register file. Reads are combinational from mem_q, so a same-cycle
   // write and read would return the old contents.
   always_ff @(posedge clk_8m or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= RST_VAL;
         end
      end else if (memWe) begin
         mem_q[memIdx] <= memWdata;
      end
   end

   // State register and all protocol registers.
   always_ff @(posedge clk_8m or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bitCnt_q  <= 4'd0;
         rxArmed_q <= 1'b0;
         shift_q   <= 7'd0;
         tx_q      <= 7'd0;
         sdaOe_q   <= 1'b0;
         ackOk_q   <= 1'b0;
         rdMode_q  <= 1'b0;
         ptr_q     <= 16'd0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         wrStb_q   <= 1'b0;
         wrAddr_q  <= 16'd0;
         wrData_q  <= 8'd0;
      end else begin
         state_q   <= state_d;
         bitCnt_q  <= bitCnt_d;
         rxArmed_q <= rxArmed_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         sdaOe_q   <= sdaOe_d;
         ackOk_q   <= ackOk_d;
         rdMode_q  <= rdMode_d;
         ptr_q     <= ptr_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         wrStb_q   <= wrStb_d;
         wrAddr_q  <= wrAddr_d;
         wrData_q  <= wrData_d;
      end
   end

   // Next-state logic.
   // bitCnt counts bits whose SCL pulse has fully ended (rise then fall), so
   // the SCL rise that precedes every START or STOP never makes a clean
   // byte boundary look like an interrupted byte. rxArmed marks that a rise
   // has been seen for the current bit, so the SCL fall right after a START
   // is not counted as a bit. Entering an ACK state leaves bitCnt at 7; the
   // 8th fall moves it to 8 and starts the ACK drive, the 9th fall ends it.
   // SDA changes only on sclFall (or on START/STOP, which release it).
   always_comb begin
      state_d   = state_q;
      bitCnt_d  = bitCnt_q;
      rxArmed_d = rxArmed_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      sdaOe_d   = sdaOe_q;
      ackOk_d   = ackOk_q;
      rdMode_d  = rdMode_q;
      ptr_d     = ptr_q;
      busy_d    = busy_q;
      err_d     = err_q;
      wrStb_d   = 1'b0;
      wrAddr_d  = wrAddr_q;
      wrData_d  = wrData_q;
      memWe     = 1'b0;
      memIdx    = ptrIdx;
      memWdata  = rxByte;
      startRead = 1'b0;

      if (startDet || stopDet) begin
         // Bus conditions win over any bit activity in the same cycle.
         if ((bitCnt_q != 4'd0) && (bitCnt_q <= 4'd7)) begin
            err_d = 1'b1;
         end
         sdaOe_d   = 1'b0;
         busy_d    = 1'b0;
         bitCnt_d  = 4'd0;
         rxArmed_d = 1'b0;
         state_d   = startDet ? ST_DEV : ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
            end

            ST_DEV, ST_REG_HI, ST_REG_LO, ST_WR_BYTE: begin
               if (sclRise) begin
                  shift_d   = rxByte[6:0];
                  rxArmed_d = 1'b1;
                  if (bitCnt_q == 4'd7) begin
                     rxArmed_d = 1'b0;
                     ackOk_d   = 1'b1;
                     case (state_q)
                        ST_DEV: begin
                           if (rxByte[7:1] == DEV_ADDR) begin
                              busy_d   = 1'b1;
                              rdMode_d = rxByte[0];
                              state_d  = ST_ACK_DEV;
                           end else begin
                              bitCnt_d = 4'd0;
                              state_d  = ST_IDLE;
                           end
                        end
                        ST_REG_HI: begin
                           ptr_d[15:8] = rxByte;
                           state_d     = ST_ACK_HI;
                        end
                        ST_REG_LO: begin
                           ptr_d[7:0] = rxByte;
                           state_d    = ST_ACK_LO;
                        end
                        default: begin
                           if (ptrInRange) begin
                              memWe    = 1'b1;
                              wrStb_d  = 1'b1;
                              wrAddr_d = ptr_q;
                              wrData_d = rxByte;
                           end else begin
                              err_d   = 1'b1;
                              ackOk_d = 1'b0;
                           end
                           state_d = ST_ACK_WR;
                        end
                     endcase
                  end
               end else if (sclFall && rxArmed_q) begin
                  bitCnt_d  = bitCnt_q + 4'd1;
                  rxArmed_d = 1'b0;
               end
            end

            ST_ACK_DEV, ST_ACK_HI, ST_ACK_LO, ST_ACK_WR: begin
               if (sclFall) begin
                  if (bitCnt_q == 4'd7) begin
                     bitCnt_d = 4'd8;
                     sdaOe_d  = ackOk_q;
                  end else begin
                     sdaOe_d  = 1'b0;
                     bitCnt_d = 4'd0;
                     case (state_q)
                        ST_ACK_DEV: begin
                           if (rdMode_q) begin
                              startRead = 1'b1;
                           end else begin
                              state_d = ST_REG_HI;
                           end
                        end
                        ST_ACK_HI: state_d = ST_REG_LO;
                        ST_ACK_LO: state_d = ST_WR_BYTE;
                        default: begin
                           ptr_d   = ptr_q + 16'd1;
                           state_d = ST_WR_BYTE;
                        end
                     endcase
                  end
               end
            end

            ST_RD_BYTE: begin
               // Bit 7 went out when the byte was loaded; each fall moves
               // on to the next bit, and the 8th fall frees the line for
               // the master's acknowledge.
               if (sclFall) begin
                  if (bitCnt_q == 4'd7) begin
                     sdaOe_d  = 1'b0;
                     bitCnt_d = 4'd8;
                     state_d  = ST_RD_ACK;
                  end else begin
                     bitCnt_d = bitCnt_q + 4'd1;
                     sdaOe_d  = ~tx_q[6];
                     tx_d     = {tx_q[5:0], 1'b0};
                  end
               end
            end

            ST_RD_ACK: begin
               // bitCnt 9 records that the master acknowledged; the next
               // byte is loaded on the fall that ends the 9th clock.
               if (sclRise && (bitCnt_q == 4'd8)) begin
                  if (sdaSync_q) begin
                     busy_d   = 1'b0;
                     bitCnt_d = 4'd0;
                     state_d  = ST_IDLE;
                  end else begin
                     ptr_d    = ptr_q + 16'd1;
                     bitCnt_d = 4'd9;
                  end
               end else if (sclFall && (bitCnt_q == 4'd9)) begin
                  startRead = 1'b1;
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      if (startRead) begin
         state_d  = ST_RD_BYTE;
         bitCnt_d = 4'd0;
         tx_d     = rdData[6:0];
         sdaOe_d  = ~rdData[7];
         if (!ptrInRange) begin
            err_d = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_iic_slave_resp.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_iic_slave_resp
// Directed bench for iic_slave_resp. A bit-level I2C master drives SCL and
// an open-drain SDA. Expected write strobes and read bytes are queued when
// the stimulus is issued and compared when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_iic_slave_resp;

   localparam int Q = 60;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wrEvT;

   logic        clk;
   logic        rst;
   logic        scl;
   logic        sdaDrvLow;
   wire         sdaBus;
   logic        busy;
   logic        wrStb;
   logic [15:0] wrAddr;
   logic [7:0]  wrData;
   logic        err;

   int   checkCount = 0;
   int   passCount  = 0;
   int   failCount  = 0;
   wrEvT wrQ[$];
   logic [7:0] rdQ[$];
   wrEvT monEv;

   pullup (sdaBus);
   assign sdaBus = sdaDrvLow ? 1'b0 : 1'bz;

   iic_slave_resp #(
      .DEV_ADDR (7'h50),
      .DEPTH    (16),
      .RST_VAL  (8'h3C)
   ) dut (
      .clk_8m  (clk),
      .rst     (rst),
      .scl     (scl),
      .sda     (sdaBus),
      .busy    (busy),
      .wr_stb  (wrStb),
      .wr_addr (wrAddr),
      .wr_data (wrData),
      .err     (err)
   );

   // 100 MHz bench clock, SCL quarter period is 6 clocks.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checkCount = checkCount + 1;
      assert (obs === exp) passCount = passCount + 1;
      else begin
         failCount = failCount + 1;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic sclVal, input logic sdaLowVal);
      scl       = sclVal;
      sdaDrvLow = sdaLowVal;
      #(Q);
   endtask

   task automatic i2cStart();
      applyStimulus(scl, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
   endtask

   task automatic i2cStop();
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0);
   endtask

   task automatic sendBit(input logic b);
      applyStimulus(1'b0, ~b);
      applyStimulus(1'b1, ~b);
      applyStimulus(1'b1, ~b);
      applyStimulus(1'b0, ~b);
   endtask

   task automatic writeByte(input logic [7:0] data, input logic expAck,
                            input string tag);
      logic ackBit;
      for (int i = 7; i >= 0; i--) begin
         sendBit(data[i]);
      end
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      ackBit = sdaBus;
      checkOutput(tag, {31'd0, ackBit}, {31'd0, expAck});
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
   endtask

   task automatic readByte(input logic ackBit, input string tag);
      logic [7:0] got;
      logic [7:0] exp;
      got = 8'd0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b0);
         applyStimulus(1'b1, 1'b0);
         got = {got[6:0], sdaBus};
         applyStimulus(1'b1, 1'b0);
         applyStimulus(1'b0, 1'b0);
      end
      sendBit(ackBit);
      if (rdQ.size() == 0) begin
         $display("[TB] read scoreboard empty at %s", tag);
         exp = 8'hXX;
      end else begin
         exp = rdQ.pop_front();
      end
      checkOutput(tag, {24'd0, got}, {24'd0, exp});
   endtask

   task automatic setAddr(input logic [15:0] addr);
      writeByte(8'hA0, 1'b0, "ack dev wr");
      writeByte(addr[15:8], 1'b0, "ack reg hi");
      writeByte(addr[7:0], 1'b0, "ack reg lo");
   endtask

   // Every write strobe must match the oldest queued write.
   always @(negedge clk) begin
      if (wrStb !== 1'b0) begin
         if (wrQ.size() == 0) begin
            checkOutput("wr_stb unexpected", {31'd0, wrStb}, 32'd0);
         end else begin
            monEv = wrQ.pop_front();
            checkOutput("wr_addr", {16'd0, wrAddr}, {16'd0, monEv.addr});
            checkOutput("wr_data", {24'd0, wrData}, {24'd0, monEv.data});
         end
      end
   end

   initial begin
      rst       = 1'b1;
      scl       = 1'b1;
      sdaDrvLow = 1'b0;
      #2;
      #(Q);
      rst = 1'b0;
      #(Q);

      $display("[TB] reset state");
      checkOutput("rst sda", {31'd0, sdaBus}, 32'd1);
      checkOutput("rst busy", {31'd0, busy}, 32'd0);
      checkOutput("rst wr_stb", {31'd0, wrStb}, 32'd0);
      checkOutput("rst wr_addr", {16'd0, wrAddr}, 32'd0);
      checkOutput("rst wr_data", {24'd0, wrData}, 32'd0);
      checkOutput("rst err", {31'd0, err}, 32'd0);

      $display("[TB] read from reset state");
      i2cStart();
      writeByte(8'hA1, 1'b0, "ack dev rd");
      checkOutput("busy after match", {31'd0, busy}, 32'd1);
      rdQ.push_back(8'h3C);
      readByte(1'b0, "rd reset b0");
      rdQ.push_back(8'h3C);
      readByte(1'b1, "rd reset b1");
      i2cStop();
      checkOutput("busy after stop", {31'd0, busy}, 32'd0);

      $display("[TB] single write");
      i2cStart();
      setAddr(16'h0003);
      checkOutput("busy mid write", {31'd0, busy}, 32'd1);
      wrQ.push_back('{addr: 16'h0003, data: 8'h5A});
      writeByte(8'h5A, 1'b0, "ack wr 5A");
      i2cStop();
      checkOutput("busy after write", {31'd0, busy}, 32'd0);
      checkOutput("err after write", {31'd0, err}, 32'd0);

      $display("[TB] random read of register 3");
      i2cStart();
      setAddr(16'h0003);
      i2cStart();
      writeByte(8'hA1, 1'b0, "ack dev rd r3");
      rdQ.push_back(8'h5A);
      readByte(1'b1, "rd reg3");
      i2cStop();

      $display("[TB] address mismatch");
      i2cStart();
      writeByte(8'hA2, 1'b1, "no ack A2");
      checkOutput("busy mismatch", {31'd0, busy}, 32'd0);
      i2cStop();
      checkOutput("busy mismatch stop", {31'd0, busy}, 32'd0);
      checkOutput("err mismatch", {31'd0, err}, 32'd0);

      $display("[TB] abort mid byte");
      i2cStart();
      setAddr(16'h0005);
      for (int i = 0; i < 4; i++) begin
         sendBit(i[0]);
      end
      i2cStop();
      #(Q);
      checkOutput("abort err", {31'd0, err}, 32'd1);
      checkOutput("abort busy", {31'd0, busy}, 32'd0);
      checkOutput("abort sda", {31'd0, sdaBus}, 32'd1);

      $display("[TB] reset during ACK");
      i2cStart();
      for (int i = 7; i >= 0; i--) begin
         sendBit(i == 7 || i == 5);
      end
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("ack before rst", {31'd0, sdaBus}, 32'd0);
      rst = 1'b1;
      #1;
      checkOutput("rst mid sda", {31'd0, sdaBus}, 32'd1);
      checkOutput("rst mid busy", {31'd0, busy}, 32'd0);
      checkOutput("rst mid err", {31'd0, err}, 32'd0);
      checkOutput("rst mid wr_stb", {31'd0, wrStb}, 32'd0);
      checkOutput("rst mid wr_addr", {16'd0, wrAddr}, 32'd0);
      checkOutput("rst mid wr_data", {24'd0, wrData}, 32'd0);
      #(Q - 1);
      applyStimulus(1'b0, 1'b0);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0);

      $display("[TB] burst write past the end");
      i2cStart();
      setAddr(16'h000E);
      wrQ.push_back('{addr: 16'h000E, data: 8'h11});
      writeByte(8'h11, 1'b0, "ack burst 11");
      wrQ.push_back('{addr: 16'h000F, data: 8'h22});
      writeByte(8'h22, 1'b0, "ack burst 22");
      writeByte(8'h33, 1'b1, "nack burst 33");
      i2cStop();
      checkOutput("burst err", {31'd0, err}, 32'd1);
      checkOutput("burst busy", {31'd0, busy}, 32'd0);

      $display("[TB] random read of burst");
      i2cStart();
      setAddr(16'h000E);
      i2cStart();
      writeByte(8'hA1, 1'b0, "ack dev rd burst");
      rdQ.push_back(8'h11);
      readByte(1'b0, "rd burst E");
      rdQ.push_back(8'h22);
      readByte(1'b1, "rd burst F");
      i2cStop();
      checkOutput("busy after read", {31'd0, busy}, 32'd0);

      $display("[TB] current address read");
      i2cStart();
      writeByte(8'hA1, 1'b0, "ack dev rd cur");
      rdQ.push_back(8'h22);
      readByte(1'b1, "rd current F");
      i2cStop();

      #(4 * Q);
      checkOutput("wr scoreboard drained", 32'(wrQ.size()), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/iic_slave_resp.md
# iic_slave_resp

I2C target (responder) that answers the 8-bit device address / 16-bit register address / 8-bit data transactions issued by the existing I2C master driver. SCL and SDA are oversampled in the `clk_8m` domain. The block holds a small register file, supports single and auto-increment burst write and read, and emits a write strobe so local logic can track register updates. It sits at the board-facing SDI/SCK pins of a bench model or companion device.

## Interface

**Parameters**
- `DEV_ADDR`, 7'h50: 7-bit target address matched against the first byte.
- `DEPTH`, 16: number of 8-bit registers, at register addresses 0..DEPTH-1. Must be a power of 2, at most 256.
- `RST_VAL`, 8'h00: reset value of every register.

**Ports**
- `clk_8m`, in, 1: system clock, at least 20x the SCL rate.
- `rst`, in, 1: asynchronous, active-high reset.
- `scl`, in, 1: I2C clock. The block never stretches SCL.
- `sda`, inout, 1: I2C data. Open-drain: the block drives 1'b0 or 1'bz only.
- `busy`, out, 1: high from an address match until STOP, START, or a NACK that ends the transfer.
- `wr_stb`, out, 1: one-cycle pulse per accepted write data byte.
- `wr_addr`, out, 16: register address of the byte flagged by `wr_stb`.
- `wr_data`, out, 8: data byte flagged by `wr_stb`.
- `err`, out, 1: sticky flag. Set on an access to an address >= DEPTH, or on a START/STOP in the middle of a byte. Cleared by `rst` only.

## Operation

**Input conditioning and bus events**
- `scl` and `sda` pass through 2-FF synchronizers. A 1-cycle history register gives `scl_rise`, `scl_fall`, `sda_rise` and `sda_fall`.
- START: `sda_fall` while synced SCL is high. STOP: `sda_rise` while synced SCL is high. Both are recognised in any state.
- START (including repeated START) goes to DEV; STOP goes to IDLE. Either one releases SDA on the same cycle.
- Bits are sampled on `scl_rise`, MSB first.
- SDA output changes only on the cycle after `scl_fall`.

**State machine**
- **IDLE**: wait for START.
- **DEV**: shift 8 bits. If bits[7:1] equal `DEV_ADDR`, go to ACK_DEV. Otherwise go to IDLE, release SDA, and keep `busy` low.
- **ACK_DEV**: drive SDA low for the 9th clock.
  - R/W=0: go to REG_HI.
  - R/W=1: go to RD_BYTE, starting from the current address pointer.
- **REG_HI**: shift 8 bits into `ptr[15:8]`, then ACK_HI.
- **ACK_HI**: ACK, then REG_LO.
- **REG_LO**: shift 8 bits into `ptr[7:0]`, then ACK_LO.
- **ACK_LO**: ACK, then WR_BYTE.
- **WR_BYTE**: shift 8 bits, then go to ACK_WR.
  - If `ptr < DEPTH`: write `mem[ptr]`, pulse `wr_stb`, ACK.
  - Otherwise: set `err` and NACK (SDA released).
- **ACK_WR**: after the 9th clock, increment `ptr` and return to WR_BYTE.
- **RD_BYTE**: present `mem[ptr]`, or 8'hFF if `ptr >= DEPTH` (also sets `err`). Drive each bit after `scl_fall`, 0 as low and 1 as Z. Then go to RD_ACK.
- **RD_ACK**: release SDA and sample the master's bit on `scl_rise`.
  - ACK (0): `ptr+1`, then RD_BYTE.
  - NACK (1): go to IDLE, release SDA, drop `busy`.

**Address and width rules**
- `ptr` is 16 bits and wraps from 16'hFFFF to 16'h0000.
- Register index is `ptr[$clog2(DEPTH)-1:0]`, used only when `ptr < DEPTH`.
- The pointer persists across transactions. A write of only the two address bytes, followed by a repeated START and read, is a random read.

## Timing

- **Reset values:** `sda` = Z, `busy` = 0, `wr_stb` = 0, `wr_addr` = 0, `wr_data` = 0, `err` = 0, `ptr` = 0, all registers = `RST_VAL`, state = IDLE.
- **Reset mid-transfer** releases SDA immediately, asynchronously.
- **Latency:**
  - Pin to internal view: 2 cycles.
  - ACK or data drive: SDA is pulled low 3 cycles after the SCL falling edge at the pin.
  - `wr_stb` fires 1 cycle after the `scl_rise` that samples the 8th data bit.
- **ACK hold:** the ACK is held until the `scl_fall` that ends the 9th clock, then released or replaced by the next read bit on the following cycle.
- **Event priority:** START/STOP take precedence over bit sampling in the same cycle. A START/STOP with a bit counter of 1-7 sets `err`.
- **Same-cycle access:** a register written and read in the same cycle returns the old value. This cannot occur on a single bus.

## Test plan

- **Single write:** write 8'hA0, 16'h0003, 8'h5A, STOP → three ACKs plus data ACK; `wr_stb` once with `wr_addr`=3, `wr_data`=8'h5A; `mem[3]`=8'h5A; `busy` back to 0 after STOP.
- **Burst write and random read:**
  - Burst write at 16'h000E of 8'h11, 8'h22, 8'h33 → strobes at addresses E and F; third byte NACKed; `err`=1.
  - Then set address 16'h000E, repeated START, 8'hA1, read 2 bytes with ACK/NACK → 8'h11, 8'h22.
- **Address mismatch:** device byte 8'hA2 → no ACK (SDA stays Z through the 9th clock), `busy` stays 0, no state change.
- **Read from reset state:** read at `ptr`=0 right after reset → returns `RST_VAL`. Pointer then advances to 1 on ACK.
- **Abort:** STOP after 4 bits of a data byte → state IDLE, SDA released, `err`=1, no `wr_stb`.
- **Reset mid-ACK:** assert `rst` while ACK is driven low → SDA goes Z within the same cycle and all outputs return to their reset values.
